// File: rtl/dm_lsu.sv
// Data memory with a load/store formatter for the MEM stage. Byte lanes are separate arrays,
// so a store writes only its selected lanes. The response is a one-deep registered slot.

module dm_lsu_lane #(
  parameter int WORD_W = 10,
  parameter bit INIT_Z = 1'b1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  localparam int DEPTH = 1 << WORD_W;

  generate
    if (INIT_Z) begin : g_zinit
      logic [7:0] mem_q [DEPTH] = '{default: 8'h00};
      always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
      end
      assign rdata = mem_q[addr];
    end else begin : g_noinit
      logic [7:0] mem_q [DEPTH];
      always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
      end
      assign rdata = mem_q[addr];
    end
  endgenerate
endmodule

module dm_lsu #(
  parameter int ADDR_W = 12,
  parameter int LANES  = 4,
  parameter bit INIT_Z = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [8*LANES-1:0]   req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [8*LANES-1:0]   rsp_rdata,
  output logic                 rsp_err
);
  localparam int OFF_W  = $clog2(LANES);
  localparam int WORD_W = ADDR_W - OFF_W;
  localparam int DATA_W = 8 * LANES;

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [OFF_W-1:0]    off;
  logic [WORD_W-1:0]   word;
  logic [3:0]          nbytes;
  logic [6:0]          nbits;
  logic                err, accept, sign;
  logic [DATA_W-1:0]   wdata_sh, rd_word, rd_sh, ld_ext;
  logic [LANES-1:0]    lane_we;
  logic [3:0]          sgn;

  assign off    = req_addr[OFF_W-1:0];
  assign word   = req_addr[ADDR_W-1:OFF_W];
  assign nbytes = 4'd1 << req_size;
  assign nbits  = 7'(nbytes) << 3;
  assign err    = ((4'(off) & (nbytes - 4'd1)) != 4'd0) || (nbytes > 4'(LANES));

  assign req_ready = !rst && ((state_q == S_EMPTY) || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Store data is right-justified; shifting by the offset lines byte k up with lane off+k.
  assign wdata_sh = req_wdata << {off, 3'b000};

  always_comb begin
    lane_we = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_we[l] = accept && req_we && !err &&
                   (l >= int'(off)) && (l < int'(off) + int'(nbytes));
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      dm_lsu_lane #(.WORD_W(WORD_W), .INIT_Z(INIT_Z)) u_lane (
        .clk   (clk),
        .we    (lane_we[l]),
        .addr  (word),
        .wdata (wdata_sh[8*l +: 8]),
        .rdata (rd_word[8*l +: 8])
      );
    end

    // Sign bit per access size; sizes wider than the word tie off (they are errors anyway).
    for (genvar s = 0; s < 4; s++) begin : g_sgn
      if ((8 << s) <= DATA_W) begin : g_ok
        assign sgn[s] = rd_sh[(8 << s) - 1];
      end else begin : g_na
        assign sgn[s] = 1'b0;
      end
    end
  endgenerate

  assign rd_sh = rd_word >> {off, 3'b000};
  assign sign  = req_signed & sgn[req_size];

  always_comb begin
    ld_ext = '0;
    for (int b = 0; b < DATA_W; b++) begin
      ld_ext[b] = (b < int'(nbits)) ? rd_sh[b] : sign;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      state_d = S_FULL;
      err_d   = err;
      rdata_d = (req_we || err) ? '0 : ld_ext;
    end else if (rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == S_FULL);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: a 4-lane instance for the main sequence and an 8-lane
// instance for doubleword accesses, every expected value written out by hand.

module tb_dm_lsu;
  logic clk, rst;

  logic        r4_valid, r4_req_ready, r4_we, r4_signed, r4_rsp_valid, r4_rdy, r4_err;
  logic [1:0]  r4_size;
  logic [11:0] r4_addr;
  logic [31:0] r4_wdata, r4_rdata;

  logic        r8_valid, r8_req_ready, r8_we, r8_signed, r8_rsp_valid, r8_rdy, r8_err;
  logic [1:0]  r8_size;
  logic [11:0] r8_addr;
  logic [63:0] r8_wdata, r8_rdata;

  int total = 0;
  int bad   = 0;
  int nrx   = 0;
  logic [31:0] bp_exp [3];

  dm_lsu #(.ADDR_W(12), .LANES(4), .INIT_Z(1'b1)) u_d4 (
    .clk(clk), .rst(rst), .req_valid(r4_valid), .req_ready(r4_req_ready), .req_we(r4_we),
    .req_size(r4_size), .req_signed(r4_signed), .req_addr(r4_addr), .req_wdata(r4_wdata),
    .rsp_valid(r4_rsp_valid), .rsp_ready(r4_rdy), .rsp_rdata(r4_rdata), .rsp_err(r4_err));

  dm_lsu #(.ADDR_W(12), .LANES(8), .INIT_Z(1'b1)) u_d8 (
    .clk(clk), .rst(rst), .req_valid(r8_valid), .req_ready(r8_req_ready), .req_we(r8_we),
    .req_size(r8_size), .req_signed(r8_signed), .req_addr(r8_addr), .req_wdata(r8_wdata),
    .rsp_valid(r8_rsp_valid), .rsp_ready(r8_rdy), .rsp_rdata(r8_rdata), .rsp_err(r8_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op4(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [11:0] a, input logic [31:0] wd);
    r4_valid = 1'b1; r4_we = we; r4_size = sz; r4_signed = sg; r4_addr = a; r4_wdata = wd;
    @(posedge clk); #1;
    r4_valid = 1'b0;
  endtask

  task automatic op8(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [11:0] a, input logic [63:0] wd);
    r8_valid = 1'b1; r8_we = we; r8_size = sz; r8_signed = sg; r8_addr = a; r8_wdata = wd;
    @(posedge clk); #1;
    r8_valid = 1'b0;
  endtask

  task automatic rsp4(input string tag, input logic [31:0] exp_d, input logic exp_e);
    chk({tag, "_valid"}, 64'(r4_rsp_valid), 64'(1'b1));
    chk({tag, "_rdata"}, 64'(r4_rdata), 64'(exp_d));
    chk({tag, "_err"}, 64'(r4_err), 64'(exp_e));
  endtask

  task automatic rsp8(input string tag, input logic [63:0] exp_d, input logic exp_e);
    chk({tag, "_valid"}, 64'(r8_rsp_valid), 64'(1'b1));
    chk({tag, "_rdata"}, r8_rdata, exp_d);
    chk({tag, "_err"}, 64'(r8_err), 64'(exp_e));
  endtask

  // One backpressure cycle: present a load, check ready, consume/check the response slot.
  task automatic bp4(input logic v, input logic [1:0] sz, input logic [11:0] a,
                     input logic rr, input logic exp_rdy);
    r4_valid = v; r4_we = 1'b0; r4_size = sz; r4_signed = 1'b0; r4_addr = a; r4_rdy = rr;
    #1;
    chk("bp_req_ready", 64'(r4_req_ready), 64'(exp_rdy));
    if (!rr) begin
      chk("bp_hold_valid", 64'(r4_rsp_valid), 64'(1'b1));
      chk("bp_hold_rdata", 64'(r4_rdata), 64'(bp_exp[nrx]));
    end
    if (r4_rsp_valid && r4_rdy) begin
      if (nrx < 3) chk("bp_order", 64'(r4_rdata), 64'(bp_exp[nrx]));
      nrx++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bp_exp[0] = 32'h8000_7FFF;
    bp_exp[1] = 32'h0000_00FF;
    bp_exp[2] = 32'h1234_5678;

    // Reset held two cycles with a store presented: nothing accepted, nothing written.
    rst = 1'b1;
    r4_valid = 1'b1; r4_we = 1'b1; r4_size = 2'd2; r4_signed = 1'b0;
    r4_addr = 12'h000; r4_wdata = 32'hFFFF_FFFF; r4_rdy = 1'b1;
    r8_valid = 1'b0; r8_we = 1'b0; r8_size = 2'd0; r8_signed = 1'b0;
    r8_addr = 12'h000; r8_wdata = 64'h0; r8_rdy = 1'b1;
    @(posedge clk); #1;
    chk("rst1_req_ready", 64'(r4_req_ready), 64'd0);
    chk("rst1_rsp_valid", 64'(r4_rsp_valid), 64'd0);
    @(posedge clk); #1;
    chk("rst2_req_ready", 64'(r4_req_ready), 64'd0);
    chk("rst2_rsp_valid", 64'(r4_rsp_valid), 64'd0);
    chk("rst2_rdata", 64'(r4_rdata), 64'd0);
    chk("rst2_err", 64'(r4_err), 64'd0);
    chk("rst2_req_ready8", 64'(r8_req_ready), 64'd0);
    rst = 1'b0;
    r4_valid = 1'b0;
    #1;
    chk("post_rst_ready", 64'(r4_req_ready), 64'd1);
    op4(1'b0, 2'd2, 1'b0, 12'h000, 32'h0);
    rsp4("rst_mem0", 32'h0000_0000, 1'b0);

    // Store / load formatting
    op4(1'b1, 2'd2, 1'b0, 12'h010, 32'h8000_80FF);
    rsp4("sw10", 32'h0, 1'b0);
    op4(1'b1, 2'd0, 1'b0, 12'h011, 32'h0000_007F);
    rsp4("sb11", 32'h0, 1'b0);
    op4(1'b0, 2'd0, 1'b1, 12'h010, 32'h0);
    rsp4("lb10", 32'hFFFF_FFFF, 1'b0);
    op4(1'b0, 2'd0, 1'b0, 12'h011, 32'h0);
    rsp4("lbu11", 32'h0000_007F, 1'b0);
    op4(1'b0, 2'd1, 1'b1, 12'h012, 32'h0);
    rsp4("lh12", 32'hFFFF_8000, 1'b0);
    op4(1'b0, 2'd1, 1'b0, 12'h012, 32'h0);
    rsp4("lhu12", 32'h0000_8000, 1'b0);
    op4(1'b0, 2'd2, 1'b1, 12'h010, 32'h0);
    rsp4("lw10", 32'h8000_7FFF, 1'b0);

    // Misaligned and illegal-size accesses
    op4(1'b1, 2'd1, 1'b0, 12'h013, 32'h0000_AAAA);
    rsp4("sh13_err", 32'h0, 1'b1);
    op4(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    rsp4("lw10_unchanged", 32'h8000_7FFF, 1'b0);
    op4(1'b0, 2'd2, 1'b0, 12'h012, 32'h0);
    rsp4("lw12_err", 32'h0, 1'b1);
    op4(1'b0, 2'd3, 1'b0, 12'h010, 32'h0);
    rsp4("ld_on4_err", 32'h0, 1'b1);

    // Store then load on the very next edge
    op4(1'b1, 2'd2, 1'b0, 12'h020, 32'h1234_5678);
    rsp4("sw20", 32'h0, 1'b0);
    op4(1'b0, 2'd2, 1'b0, 12'h020, 32'h0);
    rsp4("raw_lw20", 32'h1234_5678, 1'b0);

    // Backpressure: three loads, consumer stalls for three cycles
    @(posedge clk); #1;
    chk("bp_start_empty", 64'(r4_rsp_valid), 64'd0);
    bp4(1'b1, 2'd2, 12'h010, 1'b1, 1'b1);
    bp4(1'b1, 2'd0, 12'h010, 1'b0, 1'b0);
    bp4(1'b1, 2'd0, 12'h010, 1'b0, 1'b0);
    bp4(1'b1, 2'd0, 12'h010, 1'b0, 1'b0);
    bp4(1'b1, 2'd0, 12'h010, 1'b1, 1'b1);
    bp4(1'b1, 2'd2, 12'h020, 1'b1, 1'b1);
    bp4(1'b0, 2'd0, 12'h000, 1'b1, 1'b1);
    chk("bp_end_empty", 64'(r4_rsp_valid), 64'd0);
    chk("bp_count", 64'(nrx), 64'd3);

    // Reset mid-operation drops the pending response
    r4_rdy = 1'b0;
    op4(1'b0, 2'd2, 1'b0, 12'h010, 32'h0);
    chk("rstmid_pending", 64'(r4_rsp_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstmid_dropped", 64'(r4_rsp_valid), 64'd0);
    rst = 1'b0;
    r4_rdy = 1'b1;

    // Eight-lane instance: doubleword accesses
    op8(1'b1, 2'd3, 1'b0, 12'h008, 64'h0123_4567_89AB_CDEF);
    rsp8("sd08", 64'h0, 1'b0);
    op8(1'b0, 2'd2, 1'b1, 12'h00C, 64'h0);
    rsp8("lw0c", 64'h0000_0000_0123_4567, 1'b0);
    op8(1'b0, 2'd1, 1'b1, 12'h00A, 64'h0);
    rsp8("lh0a", 64'hFFFF_FFFF_FFFF_89AB, 1'b0);
    op8(1'b0, 2'd0, 1'b1, 12'h00F, 64'h0);
    rsp8("lb0f", 64'h0000_0000_0000_0001, 1'b0);
    op8(1'b1, 2'd3, 1'b0, 12'h004, 64'hFFFF_FFFF_FFFF_FFFF);
    rsp8("sd04_err", 64'h0, 1'b1);
    op8(1'b0, 2'd2, 1'b0, 12'h004, 64'h0);
    rsp8("lw04_untouched", 64'h0, 1'b0);
    op8(1'b0, 2'd3, 1'b0, 12'h008, 64'h0);
    rsp8("ld08", 64'h0123_4567_89AB_CDEF, 1'b0);

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
